// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - datapath/divider handshake bundle; unsigned_op exists only with DIVU_EN
interface seq_divider_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
`ifdef DIVU_EN
  logic        unsigned_op;
`endif
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_zero;

`ifdef DIVU_EN
  modport master (output start, dividend, divisor, unsigned_op,
                  input  hi_out, lo_out, busy, done, div_zero);
  modport slave  (input  start, dividend, divisor, unsigned_op,
                  output hi_out, lo_out, busy, done, div_zero);
`else
  modport master (output start, dividend, divisor,
                  input  hi_out, lo_out, busy, done, div_zero);
  modport slave  (input  start, dividend, divisor,
                  output hi_out, lo_out, busy, done, div_zero);
`endif
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - 32-bit multi-cycle restoring divider (MIPS DIV; DIVU when DIVU_EN is defined)
module seq_divider (
  input  logic          clock,
  input  logic          reset,
  seq_divider_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [5:0]  count;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dividendShift;
  logic [31:0] absDivisor;
  logic        negQuo;
  logic        negRem;
  logic [31:0] hiReg;
  logic [31:0] loReg;
  logic        busyReg;
  logic        doneReg;
  logic        divZeroReg;
  logic        signedOp;
  logic [32:0] remShift;
  logic        remGe;

`ifdef DIVU_EN
  assign signedOp = ~bus.unsigned_op;
`else
  assign signedOp = 1'b1;
`endif

  // Dividend magnitude is shifted out MSB-first into the partial remainder.
  assign remShift = {rem, dividendShift[31]};
  assign remGe    = (remShift >= {1'b0, absDivisor});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= '0;
      rem           <= '0;
      quo           <= '0;
      dividendShift <= '0;
      absDivisor    <= '0;
      negQuo        <= 1'b0;
      negRem        <= 1'b0;
      hiReg         <= '0;
      loReg         <= '0;
      busyReg       <= 1'b0;
      doneReg       <= 1'b0;
      divZeroReg    <= 1'b0;
    end else begin
      doneReg    <= 1'b0;
      divZeroReg <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (!bus.start) begin
            state <= IDLE;
          end else if (bus.divisor == 32'd0) begin
            state      <= DONE;
            doneReg    <= 1'b1;
            divZeroReg <= 1'b1;
          end else begin
            // Negating 0x80000000 yields 0x80000000, which is the exact unsigned magnitude.
            dividendShift <= (signedOp && bus.dividend[31]) ? -bus.dividend : bus.dividend;
            absDivisor    <= (signedOp && bus.divisor[31])  ? -bus.divisor  : bus.divisor;
            negQuo        <= signedOp && (bus.dividend[31] ^ bus.divisor[31]);
            negRem        <= signedOp && bus.dividend[31];
            count         <= '0;
            rem           <= '0;
            quo           <= '0;
            busyReg       <= 1'b1;
            state         <= CALC;
          end
        end
        CALC: begin
          dividendShift <= {dividendShift[30:0], 1'b0};
          if (remGe) begin
            rem <= remShift[31:0] - absDivisor;
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= remShift[31:0];
            quo <= {quo[30:0], 1'b0};
          end
          count <= count + 6'd1;
          if (count == 6'd31) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          loReg   <= negQuo ? -quo : quo;
          hiReg   <= negRem ? -rem : rem;
          busyReg <= 1'b0;
          doneReg <= 1'b1;
          state   <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi_out   = hiReg;
  assign bus.lo_out   = loReg;
  assign bus.busy     = busyReg;
  assign bus.done     = doneReg;
  assign bus.div_zero = divZeroReg;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed vector bench for seq_divider (DIVU_EN cases when the macro is defined)
module tb_seq_divider;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seq_divider_if bus ();
  seq_divider dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } divVec;

  divVec vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge of the first cycle after the accepting edge.
  task automatic startOp(input logic [31:0] a, input logic [31:0] b, input logic uns);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
`ifdef DIVU_EN
    bus.unsigned_op = uns;
`endif
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic waitDone(output int doneAt, output int busyCnt);
    doneAt  = 1;
    busyCnt = 0;
    while (!bus.done && doneAt < 100) begin
      if (bus.busy) busyCnt++;
      @(negedge clock);
      doneAt++;
    end
  endtask

  task automatic runVec(input string tag, input divVec v, input logic uns);
    int doneAt;
    int busyCnt;
    startOp(v.a, v.b, uns);
    waitDone(doneAt, busyCnt);
    check({tag, " latency"}, doneAt, v.dz ? 1 : 34);
    check({tag, " busy cycles"}, busyCnt, v.dz ? 0 : 33);
    check({tag, " busy in done"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " lo"}, bus.lo_out, v.lo);
    check({tag, " hi"}, bus.hi_out, v.hi);
    check({tag, " div_zero"}, {31'd0, bus.div_zero}, {31'd0, v.dz});
    @(negedge clock);
    check({tag, " done pulse width"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int doneAt;
    int busyCnt;
    divVec v;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1] = '{32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2] = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[3] = '{32'd55,         32'd0,          32'h80000000,   32'd0,          1'b1};
    vecs[4] = '{32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[5] = '{32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
    vecs[6] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    vecs[7] = '{32'hFFFFFFFF,   32'd2,          32'd0,          32'hFFFFFFFF,   1'b0};
    vecs[8] = '{32'd123456,     32'd1,          32'd123456,     32'd0,          1'b0};
    vecs[9] = '{32'd5,          32'd0,          32'd123456,     32'd0,          1'b1};

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
`ifdef DIVU_EN
    bus.unsigned_op = 1'b0;
`endif
    repeat (3) @(negedge clock);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset lo", bus.lo_out, 32'd0);
    check("reset hi", bus.hi_out, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("post-reset div_zero", {31'd0, bus.div_zero}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      runVec($sformatf("vec%0d", i), vecs[i], 1'b0);
    end

    // Back-to-back: second start issued during the done cycle of the first.
    startOp(32'd50, 32'd5, 1'b0);
    waitDone(doneAt, busyCnt);
    check("b2b first lo", bus.lo_out, 32'd10);
    startOp(32'hFFFFFFF7, 32'd4, 1'b0);
    waitDone(doneAt, busyCnt);
    check("b2b latency", doneAt, 34);
    check("b2b lo", bus.lo_out, 32'hFFFFFFFE);
    check("b2b hi", bus.hi_out, 32'hFFFFFFFF);
    @(negedge clock);

    // A start pulse while busy must not disturb the running operation.
    startOp(32'd100, 32'd7, 1'b0);
    doneAt = 1;
    while (!bus.done && doneAt < 100) begin
      if (doneAt == 5) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clock);
      doneAt++;
    end
    bus.start = 1'b0;
    check("ignore-start latency", doneAt, 34);
    check("ignore-start lo", bus.lo_out, 32'd14);
    check("ignore-start hi", bus.hi_out, 32'd2);
    @(negedge clock);

    // Reset mid-operation clears everything immediately.
    startOp(32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midreset busy", {31'd0, bus.busy}, 32'd0);
    check("midreset done", {31'd0, bus.done}, 32'd0);
    check("midreset lo", bus.lo_out, 32'd0);
    check("midreset hi", bus.hi_out, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("idle%0d busy", i), {31'd0, bus.busy}, 32'd0);
      check($sformatf("idle%0d done", i), {31'd0, bus.done}, 32'd0);
    end
    v = '{32'd1000, 32'd3, 32'd333, 32'd1, 1'b0};
    runVec("after-reset", v, 1'b0);

`ifdef DIVU_EN
    v = '{32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, 1'b0};
    runVec("divu", v, 1'b1);
    v = '{32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF, 1'b0};
    runVec("div-signed", v, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
